// File: rtl/uart_frame_parser.sv
// Frame assembler behind the UART receiver: SOF, CMD, LEN, payload, XOR CHK.
// Verified frames are held on a single-entry valid/ready output.
module uart_frame_parser #(
    parameter int unsigned MAX_PAYLOAD  = 16,
    parameter logic [7:0]  SOF_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 21700
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_RX_DV,
    input  logic [7:0]               i_RX_Byte,
    output logic                     o_frame_valid,
    input  logic                     i_frame_ready,
    output logic [7:0]               o_cmd,
    output logic [7:0]               o_len,
    output logic [8*MAX_PAYLOAD-1:0] o_payload,
    output logic                     o_err_chk,
    output logic                     o_err_len,
    output logic                     o_err_timeout,
    output logic                     o_err_overrun
);

    localparam int unsigned CW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] MAX_B = 8'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        HUNT, GET_CMD, GET_LEN, GET_PAY, GET_CHK, HOLD
    } state_t;

    state_t                   state_q, d_state;
    logic [7:0]               cmd_q, d_cmd;
    logic [7:0]               len_q, d_len;
    logic [7:0]               idx_q, d_idx;
    logic [7:0]               chk_q, d_chk;
    logic [8*MAX_PAYLOAD-1:0] pay_q, d_pay;
    logic [CW-1:0]            cnt_q, d_cnt;
    logic                     e_chk_q, e_len_q, e_to_q, e_ovr_q;
    logic                     d_e_chk, d_e_len, d_e_to, d_e_ovr;
    logic                     sof;

    assign sof = i_RX_DV && (i_RX_Byte == SOF_BYTE);

    always_comb begin
        d_state = state_q;
        d_cmd   = cmd_q;
        d_len   = len_q;
        d_idx   = idx_q;
        d_chk   = chk_q;
        d_pay   = pay_q;
        d_cnt   = cnt_q;
        d_e_chk = 1'b0;
        d_e_len = 1'b0;
        d_e_to  = 1'b0;
        d_e_ovr = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (sof) begin
                    d_state = GET_CMD;
                    d_pay   = '0;
                    d_chk   = 8'h00;
                    d_len   = 8'h00;
                end
            end
            GET_CMD: begin
                if (i_RX_DV) begin
                    d_cmd   = i_RX_Byte;
                    d_chk   = i_RX_Byte;
                    d_state = GET_LEN;
                end
            end
            GET_LEN: begin
                if (i_RX_DV) begin
                    d_chk = chk_q ^ i_RX_Byte;
                    d_idx = 8'h00;
                    if (i_RX_Byte > MAX_B) begin
                        d_e_len = 1'b1;
                        d_state = HUNT;
                    end else begin
                        d_len   = i_RX_Byte;
                        d_state = (i_RX_Byte == 8'h00) ? GET_CHK : GET_PAY;
                    end
                end
            end
            GET_PAY: begin
                if (i_RX_DV) begin
                    for (int k = 0; k < int'(MAX_PAYLOAD); k++) begin
                        if (idx_q == 8'(k)) d_pay[k*8 +: 8] = i_RX_Byte;
                    end
                    d_chk = chk_q ^ i_RX_Byte;
                    d_idx = idx_q + 8'd1;
                    if ((idx_q + 8'd1) == len_q) d_state = GET_CHK;
                end
            end
            GET_CHK: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte == chk_q) begin
                        d_state = HOLD;
                    end else begin
                        d_e_chk = 1'b1;
                        d_state = HUNT;
                    end
                end
            end
            HOLD: begin
                // A byte on the transfer cycle is treated as HUNT input
                if (i_frame_ready) begin
                    d_state = HUNT;
                    if (sof) begin
                        d_state = GET_CMD;
                        d_pay   = '0;
                        d_chk   = 8'h00;
                        d_len   = 8'h00;
                    end
                end else if (i_RX_DV) begin
                    d_e_ovr = 1'b1;
                end
            end
            default: d_state = HUNT;
        endcase

        if (state_q inside {GET_CMD, GET_LEN, GET_PAY, GET_CHK}) begin
            if (i_RX_DV) begin
                d_cnt = '0;
            end else if (cnt_q == T_LAST) begin
                d_e_to  = 1'b1;
                d_state = HUNT;
                d_cnt   = '0;
            end else begin
                d_cnt = cnt_q + 1'b1;
            end
        end else begin
            d_cnt = '0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= HUNT;
            cmd_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            pay_q   <= '0;
            cnt_q   <= '0;
            e_chk_q <= 1'b0;
            e_len_q <= 1'b0;
            e_to_q  <= 1'b0;
            e_ovr_q <= 1'b0;
        end else begin
            state_q <= d_state;
            cmd_q   <= d_cmd;
            len_q   <= d_len;
            idx_q   <= d_idx;
            chk_q   <= d_chk;
            pay_q   <= d_pay;
            cnt_q   <= d_cnt;
            e_chk_q <= d_e_chk;
            e_len_q <= d_e_len;
            e_to_q  <= d_e_to;
            e_ovr_q <= d_e_ovr;
        end
    end

    assign o_frame_valid = (state_q == HOLD);
    assign o_cmd         = cmd_q;
    assign o_len         = len_q;
    assign o_payload     = pay_q;
    assign o_err_chk     = e_chk_q;
    assign o_err_len     = e_len_q;
    assign o_err_timeout = e_to_q;
    assign o_err_overrun = e_ovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with immediate-assertion checks.
// Error pulses are also totalled on the falling edge and checked at the end.
module tb_uart_frame_parser;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_dv = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         ready = 1'b0;
    logic         valid;
    logic [7:0]   cmd;
    logic [7:0]   len;
    logic [127:0] payload;
    logic         e_chk, e_len, e_to, e_ovr;

    int tests = 0;
    int fails = 0;
    int n_chk = 0;
    int n_len = 0;
    int n_to  = 0;
    int n_ovr = 0;

    uart_frame_parser dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_RX_DV       (rx_dv),
        .i_RX_Byte     (rx_byte),
        .o_frame_valid (valid),
        .i_frame_ready (ready),
        .o_cmd         (cmd),
        .o_len         (len),
        .o_payload     (payload),
        .o_err_chk     (e_chk),
        .o_err_len     (e_len),
        .o_err_timeout (e_to),
        .o_err_overrun (e_ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (e_chk) n_chk++;
        if (e_len) n_len++;
        if (e_to)  n_to++;
        if (e_ovr) n_ovr++;
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dv = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    task automatic good_frame();
        send(8'hA5); send(8'h10); send(8'h02);
        send(8'h34); send(8'h56); send(8'h70);
    endtask

    task automatic check_good(input string tag);
        check({tag, "_valid"}, 128'(valid), 128'd1);
        check({tag, "_cmd"}, 128'(cmd), 128'h10);
        check({tag, "_len"}, 128'(len), 128'h02);
        check({tag, "_pay"}, payload, 128'h5634);
    endtask

    task automatic xfer(input string tag);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        check({tag, "_drop"}, 128'(valid), 128'd0);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 128'({valid, cmd, len, e_chk, e_len, e_to, e_ovr}), 128'd0);
        check({tag, "_pay"}, payload, 128'd0);
    endtask

    initial begin
        #12;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // good frame
        good_frame();
        check_good("good");
        xfer("good");

        // bad checksum, then good frame
        send(8'hA5); send(8'h10); send(8'h02);
        send(8'h34); send(8'h56); send(8'h71);
        check("badchk_pulse", 128'(e_chk), 128'd1);
        check("badchk_valid", 128'(valid), 128'd0);
        @(posedge clk); #1;
        check("badchk_one_cycle", 128'(e_chk), 128'd0);
        good_frame();
        check_good("after_bad");
        xfer("after_bad");

        // oversize length, then zero-length frame
        send(8'hA5); send(8'h10); send(8'h11);
        check("len_pulse", 128'(e_len), 128'd1);
        check("len_valid", 128'(valid), 128'd0);
        send(8'hA5); send(8'h20); send(8'h00); send(8'h20);
        check("zero_valid", 128'(valid), 128'd1);
        check("zero_cmd", 128'(cmd), 128'h20);
        check("zero_len", 128'(len), 128'h00);
        check("zero_pay", payload, 128'd0);
        xfer("zero");

        // hunt ignores junk, then inter-byte timeout
        send(8'h00); send(8'hFF);
        check("hunt_errs", 128'(n_chk + n_len + n_to + n_ovr), 128'd2);
        send(8'hA5); send(8'h10);
        repeat (21699) @(posedge clk);
        #1;
        check("to_not_yet", 128'(e_to), 128'd0);
        @(posedge clk); #1;
        check("to_pulse", 128'(e_to), 128'd1);
        @(posedge clk); #1;
        check("to_one_cycle", 128'(e_to), 128'd0);
        good_frame();
        check_good("after_to");
        xfer("after_to");

        // backpressure and overrun
        good_frame();
        send(8'h11);
        check("ovr1", 128'(e_ovr), 128'd1);
        send(8'h22);
        check("ovr2", 128'(e_ovr), 128'd1);
        send(8'h33);
        check("ovr3", 128'(e_ovr), 128'd1);
        check_good("held");
        @(posedge clk); #1;
        rx_dv = 1'b1;
        rx_byte = 8'hA5;
        ready = 1'b1;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        ready = 1'b0;
        check("xfer_sof_valid", 128'(valid), 128'd0);
        check("xfer_sof_ovr", 128'(e_ovr), 128'd0);
        send(8'h20); send(8'h00); send(8'h20);
        check("xfer_sof_frame", 128'({valid, cmd, len}), 128'h1_20_00);
        xfer("xfer_sof");

        // reset in the middle of the payload
        send(8'hA5); send(8'h10); send(8'h02); send(8'h34);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("midreset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        good_frame();
        check_good("after_reset");
        xfer("after_reset");

        @(posedge clk); #1;
        check("tot_chk", 128'(n_chk), 128'd1);
        check("tot_len", 128'(n_len), 128'd1);
        check("tot_to", 128'(n_to), 128'd1);
        check("tot_ovr", 128'(n_ovr), 128'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
